// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider sequencer and its helpers.
// div_state_t is the sequencer FSM encoding; DIV_W matches the iterative divider width.
package div_pkg;
    localparam int DIV_W = 32;
    localparam logic [DIV_W-1:0] DIV_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_ARM,
        ST_WAIT,
        ST_FIX,
        ST_DONE
    } div_state_t;
endpackage

// File: rtl/div_ctrl_if.sv
// CPU-side request/response bundle: the pipeline drives requests and flush (master),
// the sequencer returns ready, stall and the corrected HI/LO result (slave).
interface div_ctrl_if import div_pkg::*; #(parameter int W = DIV_W);
    logic         req_valid;
    logic         req_signed;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_ready;
    logic         flush;
    logic         rsp_valid;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dbz;
    logic         busy;

    modport master (
        output req_valid, req_signed, req_a, req_b, flush,
        input  req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, busy
    );
    modport slave (
        input  req_valid, req_signed, req_a, req_b, flush,
        output req_ready, rsp_valid, rsp_q, rsp_r, rsp_dbz, busy
    );
endinterface

// File: rtl/div_ctrl_signfix.sv
// Conditional two's-complement negate; combinational, zero latency, no handshake.
module div_signfix #(parameter int W = 32) (
    input  logic         neg,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);
    assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;
endmodule

// File: rtl/div_ctrl.sv
// Sequencer for the shared iterative divider: magnitude conversion, launch, wait, sign fix.
// Result 37 cycles after accept (2 for a zero divisor when DIV_ZERO_BYPASS_EN is defined); req_ready only in IDLE.
module div_ctrl import div_pkg::*; #(parameter int W = DIV_W) (
    input  logic         clock,
    input  logic         reset_n,
    div_ctrl_if.slave    cpu,
    output logic         div_ena,
    output logic         div_start,
    output logic [W-1:0] div_dividend,
    output logic [W-1:0] div_divisor,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    input  logic         div_busy
);
    div_state_t   state_q, state_d;
    logic         sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d;
    logic [W-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic [W-1:0] q_raw_q, q_raw_d, r_raw_q, r_raw_d;
    logic [W-1:0] rsp_q_q, rsp_q_d, rsp_r_q, rsp_r_d;
    logic         rsp_dbz_q, rsp_dbz_d;
    logic         div_ena_q, div_ena_d;

    logic         accept, aborting, sa_in, sb_in, b_zero;
    logic [W-1:0] a_abs, b_abs, q_fix, r_fix;

    assign accept   = (state_q == ST_IDLE) && cpu.req_valid;
    assign aborting = (state_q != ST_IDLE) && cpu.flush;
    assign sa_in    = cpu.req_signed & cpu.req_a[W-1];
    assign sb_in    = cpu.req_signed & cpu.req_b[W-1];
    assign b_zero   = (cpu.req_b == '0);

    div_signfix #(.W(W)) u_a_abs (.neg(sa_in),       .x(cpu.req_a), .y(a_abs));
    div_signfix #(.W(W)) u_b_abs (.neg(sb_in),       .x(cpu.req_b), .y(b_abs));
    div_signfix #(.W(W)) u_q_fix (.neg(sa_q ^ sb_q), .x(q_raw_q),   .y(q_fix));
    div_signfix #(.W(W)) u_r_fix (.neg(sa_q),        .x(r_raw_q),   .y(r_fix));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over every transition, including DONE.
    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu.req_valid) begin
`ifdef DIV_ZERO_BYPASS_EN
                        state_d = b_zero ? ST_FIX : ST_LAUNCH;
`else
                        state_d = ST_LAUNCH;
`endif
                    end
                end
                ST_LAUNCH: state_d = ST_ARM;
                ST_ARM:    state_d = ST_WAIT;
                ST_WAIT:   if (!div_busy) state_d = ST_FIX;
                ST_FIX:    state_d = ST_DONE;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cpu.req_ready = (state_q == ST_IDLE);
        cpu.busy      = (state_q != ST_IDLE);
        cpu.rsp_valid = (state_q == ST_DONE);
        div_start     = (state_q == ST_LAUNCH);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dbz_q     <= 1'b0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            q_raw_q   <= '0;
            r_raw_q   <= '0;
            rsp_q_q   <= '0;
            rsp_r_q   <= '0;
            rsp_dbz_q <= 1'b0;
            div_ena_q <= 1'b1;
        end else begin
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            dbz_q     <= dbz_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            q_raw_q   <= q_raw_d;
            r_raw_q   <= r_raw_d;
            rsp_q_q   <= rsp_q_d;
            rsp_r_q   <= rsp_r_d;
            rsp_dbz_q <= rsp_dbz_d;
            div_ena_q <= div_ena_d;
        end
    end

    always_comb begin
        sa_d      = sa_q;
        sb_d      = sb_q;
        dbz_d     = dbz_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        q_raw_d   = q_raw_q;
        r_raw_d   = r_raw_q;
        rsp_q_d   = rsp_q_q;
        rsp_r_d   = rsp_r_q;
        rsp_dbz_d = rsp_dbz_q;
        // A single low cycle on div_ena clears the divider after an abort.
        div_ena_d = !aborting;

        if (accept) begin
            sa_d    = sa_in;
            sb_d    = sb_in;
            dbz_d   = b_zero;
            a_mag_d = a_abs;
            b_mag_d = b_abs;
`ifdef DIV_ZERO_BYPASS_EN
            // Reproduce the divider's divide-by-zero answer without running it.
            if (b_zero) begin
                q_raw_d = W'(DIV_ALL_ONES);
                r_raw_d = a_abs;
            end
`endif
        end

        if (state_q == ST_WAIT && !div_busy && !aborting) begin
            q_raw_d = div_q;
            r_raw_d = div_r;
        end

        if (state_q == ST_FIX && !aborting) begin
            rsp_q_d   = q_fix;
            rsp_r_d   = r_fix;
            rsp_dbz_d = dbz_q;
        end
    end

    assign cpu.rsp_q   = rsp_q_q;
    assign cpu.rsp_r   = rsp_r_q;
    assign cpu.rsp_dbz = rsp_dbz_q;
    assign div_ena      = div_ena_q;
    assign div_dividend = a_mag_q;
    assign div_divisor  = b_mag_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: 32-step divider model, vector table, scoreboard, flush and reset sequences.
module tb_div_ctrl;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         div_ena, div_start, div_busy;
    logic [W-1:0] div_dividend, div_divisor, div_q, div_r;

    div_ctrl_if #(.W(W)) cpu_if ();

    div_ctrl #(.W(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cpu          (cpu_if),
        .div_ena      (div_ena),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_q        (div_q),
        .div_r        (div_r),
        .div_busy     (div_busy)
    );

    always #5 clock = ~clock;

    // Divider model: registers start, raises busy the cycle after, then 32 busy cycles.
    logic m_start_d;
    int   m_cnt;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_start_d <= 1'b0;
            m_cnt     <= 0;
            div_q     <= '0;
            div_r     <= '0;
        end else if (!div_ena) begin
            m_start_d <= 1'b0;
            m_cnt     <= 0;
        end else begin
            m_start_d <= div_start;
            if (m_start_d) begin
                m_cnt <= 32;
                if (div_divisor == '0) begin
                    div_q <= '1;
                    div_r <= div_dividend;
                end else begin
                    div_q <= div_dividend / div_divisor;
                    div_r <= div_dividend % div_divisor;
                end
            end else if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
            end
        end
    end
    assign div_busy = (m_cnt != 0);

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        int sa, sbv;
        sa  = a;
        sbv = b;
        if (b == '0) begin
            q = (s && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
        end else if (s) begin
            q = sa / sbv;
            r = sa % sbv;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic run_req(input vec_t v);
        exp_t         e, got;
        int           lat, nbusy, exp_lat;
        logic         bypass;
        logic [W-1:0] am, bm;
        bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        bypass = (v.b == '0);
`endif
        exp_lat = bypass ? 2 : 37;
        am = (v.s && v.a[W-1]) ? -v.a : v.a;
        bm = (v.s && v.b[W-1]) ? -v.b : v.b;

        @(negedge clock);
        check("req_ready_idle", {31'd0, cpu_if.req_ready}, 1);
        cpu_if.req_valid  = 1'b1;
        cpu_if.req_signed = v.s;
        cpu_if.req_a      = v.a;
        cpu_if.req_b      = v.b;
        e.q = v.q; e.r = v.r; e.dbz = v.dbz;
        sb.push_back(e);

        @(negedge clock);
        cpu_if.req_valid = 1'b0;
        check("div_start", {31'd0, div_start}, {31'd0, !bypass});
        if (!bypass) begin
            check("div_dividend", div_dividend, am);
            check("div_divisor", div_divisor, bm);
        end

        lat = 1;
        nbusy = 0;
        while (1) begin
            if (cpu_if.busy) nbusy++;
            if (cpu_if.rsp_valid || lat >= 100) break;
            @(negedge clock);
            lat++;
        end
        if (!cpu_if.rsp_valid) begin
            fail_now("rsp_valid_timeout");
            return;
        end
        if (sb.size() == 0) begin
            fail_now("unexpected_rsp");
            return;
        end
        got = sb.pop_front();
        check("rsp_q", cpu_if.rsp_q, got.q);
        check("rsp_r", cpu_if.rsp_r, got.r);
        check("rsp_dbz", {31'd0, cpu_if.rsp_dbz}, {31'd0, got.dbz});
        check("latency", lat, exp_lat);
        check("busy_cycles", nbusy, exp_lat);

        @(negedge clock);
        check("rsp_valid_pulse", {31'd0, cpu_if.rsp_valid}, 0);
        check("busy_after", {31'd0, cpu_if.busy}, 0);
        check("rsp_q_hold", cpu_if.rsp_q, got.q);
    endtask

    vec_t vecs[10];

    initial begin
        vec_t v;
        int   nrsp;

        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
        vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
        vecs[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
        vecs[5] = '{1'b0, 32'hFFFF_FF9C,  32'd7,          32'h2492_4916,  32'd2,          1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB,  1'b1};
        vecs[7] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
        vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[9] = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0};

        cpu_if.req_valid  = 1'b0;
        cpu_if.req_signed = 1'b0;
        cpu_if.req_a      = '0;
        cpu_if.req_b      = '0;
        cpu_if.flush      = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_rsp_valid", {31'd0, cpu_if.rsp_valid}, 0);
        check("rst_busy", {31'd0, cpu_if.busy}, 0);
        check("rst_div_start", {31'd0, div_start}, 0);
        check("rst_div_ena", {31'd0, div_ena}, 1);
        check("rst_rsp_q", cpu_if.rsp_q, 0);
        check("rst_dividend", div_dividend, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_req(vecs[i]);

        for (int i = 0; i < 4; i++) begin
            v.s = 1'($urandom_range(0, 1));
            v.a = $urandom;
            v.b = $urandom_range(1, 5000);
            if (i == 3) v.b = -v.b;
            ref_div(v.s, v.a, v.b, v.q, v.r);
            v.dbz = 1'b0;
            run_req(v);
        end

        // Flush in WAIT, then a fresh request must complete normally.
        @(negedge clock);
        cpu_if.req_valid = 1'b1;
        cpu_if.req_signed = 1'b0;
        cpu_if.req_a = 32'd1000;
        cpu_if.req_b = 32'd3;
        @(negedge clock);
        cpu_if.req_valid = 1'b0;
        repeat (9) @(negedge clock);
        cpu_if.flush = 1'b1;
        @(negedge clock);
        check("flush_div_ena_low", {31'd0, div_ena}, 0);
        check("flush_idle", {31'd0, cpu_if.busy}, 0);
        check("flush_ready", {31'd0, cpu_if.req_ready}, 1);
        @(negedge clock);
        check("flush_in_idle_ignored", {31'd0, div_ena}, 1);
        cpu_if.flush = 1'b0;
        nrsp = 0;
        repeat (45) begin
            @(negedge clock);
            if (cpu_if.rsp_valid) nrsp++;
        end
        check("flush_no_rsp", nrsp, 0);
        v = '{1'b0, 32'd9, 32'd2, 32'd4, 32'd1, 1'b0};
        run_req(v);

        // Asynchronous reset mid-WAIT.
        @(negedge clock);
        cpu_if.req_valid = 1'b1;
        cpu_if.req_signed = 1'b1;
        cpu_if.req_a = 32'hFFFF_FF9C;
        cpu_if.req_b = 32'd7;
        @(negedge clock);
        cpu_if.req_valid = 1'b0;
        repeat (15) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, cpu_if.busy}, 0);
        check("arst_rsp_q", cpu_if.rsp_q, 0);
        check("arst_rsp_r", cpu_if.rsp_r, 0);
        check("arst_div_ena", {31'd0, div_ena}, 1);
        check("arst_div_start", {31'd0, div_start}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("arst_ready", {31'd0, cpu_if.req_ready}, 1);
        nrsp = 0;
        repeat (45) begin
            @(negedge clock);
            if (cpu_if.rsp_valid) nrsp++;
        end
        check("arst_no_rsp", nrsp, 0);
        v = '{1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0};
        run_req(v);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer sitting between the CPU control unit and the shared 32-step iterative unsigned divider.
- Accepts DIV (signed) and DIVU requests and converts signed operands to magnitudes.
- Pulses the divider start, waits on its busy flag, sign-corrects the quotient and remainder, and returns them for HI/LO writeback.
- Stalls the pipeline while a request is in progress and supports abort (flush) mid-operation.

Parameters:
- W, 32, operand/result width; must match the divider width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_signed  in  1  1 = DIV, 0 = DIVU
- req_a  in  W  dividend
- req_b  in  W  divisor
- req_ready  out  1  high only in IDLE
- flush  in  1  abort current operation
- rsp_valid  out  1  one-cycle result pulse
- rsp_q  out  W  quotient (HI/LO source)
- rsp_r  out  W  remainder
- rsp_dbz  out  1  divisor was zero (valid with rsp_valid)
- busy  out  1  stall to pipeline; high whenever state != IDLE
- div_ena  out  1  divider enable; low clears the divider
- div_start  out  1  divider start pulse
- div_dividend  out  W  magnitude of dividend
- div_divisor  out  W  magnitude of divisor
- div_q  in  W  divider quotient
- div_r  in  W  divider remainder
- div_busy  in  1  divider busy

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - State IDLE.
  - rsp_valid = 0, rsp_q = 0, rsp_r = 0, rsp_dbz = 0, busy = 0, div_start = 0.
  - div_ena = 1; operand registers = 0.
- States: IDLE, LAUNCH, ARM, WAIT, FIX, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the sign flags: sa = req_signed & a[W-1], sb = req_signed & b[W-1].
  - Latch magnitudes: |a| (two's-complement negate if sa), |b| likewise. Latch dbz = (req_b == 0).
  - Go to LAUNCH.
- LAUNCH:
  - div_start = 1 for exactly one cycle; operands are held stable on div_dividend/div_divisor.
  - Go to ARM.
- ARM:
  - One-cycle guard, because the divider raises busy one cycle after start. div_busy is not sampled here.
  - Go to WAIT.
- WAIT:
  - Stay while div_busy = 1.
  - When div_busy = 0, capture div_q/div_r and go to FIX.
- FIX:
  - rsp_q = (sa ^ sb) ? -q : q.
  - rsp_r = sa ? -r : r.
  - Go to DONE.
- DONE:
  - rsp_valid = 1 for one cycle.
  - rsp_q, rsp_r and rsp_dbz hold their values until the next FIX.
  - Go to IDLE.
- Latency: with the 32-step divider, rsp_valid asserts 37 cycles after the accept cycle (accept = cycle 0). Back-to-back requests are accepted in the cycle after DONE.
- Divide by zero (no bypass): forwarded to the divider. The divider yields q = all-ones and r = |a|, then sign correction is applied; rsp_dbz = 1.
- Overflow (-2^31 / -1, signed): rsp_q = 0x80000000, rsp_r = 0. No trap.
- flush:
  - In any non-IDLE state, go to IDLE next cycle with div_ena = 0 for that one cycle, which clears the divider.
  - No rsp_valid is produced.
  - flush in IDLE is ignored. flush has priority over every other transition, including DONE.
- req_valid outside IDLE is ignored; the requester holds it until it sees req_ready.
- Asynchronous reset mid-operation: the divider is cleared by its own reset; div_ctrl returns to IDLE with no response.

Optional Feature:
- Macro DIV_ZERO_BYPASS_EN.
- Defined:
  - IDLE with req_b == 0 goes directly to FIX, using q = all-ones and r = |a| without starting the divider.
  - Result is identical to the non-bypassed result.
  - rsp_valid asserts at cycle 2 after accept.
  - div_start stays 0.
- Undefined: the zero divisor takes the full divider path (37 cycles).

Decomposition:
- Shared package div_pkg:
  - State enum div_state_t.
  - Constant DIV_W = 32.
  - Constant DIV_ALL_ONES.
- Optional sub-module div_signfix (combinational conditional negate, instanced for operand magnitude and result correction). Otherwise everything is flat in div_ctrl.

Test Plan:
- DIVU a = 100, b = 7 -> rsp_q = 14, rsp_r = 2, rsp_dbz = 0; rsp_valid at cycle 37; busy high cycles 1..37.
- DIV a = -100 (0xFFFFFF9C), b = 7 -> rsp_q = 0xFFFFFFF2 (-14), rsp_r = 0xFFFFFFFE (-2).
- DIV a = 100, b = -7 -> rsp_q = -14, rsp_r = 2. DIV a = 0x80000000, b = 0xFFFFFFFF -> rsp_q = 0x80000000, rsp_r = 0.
- DIVU a = 5, b = 0 -> rsp_q = 0xFFFFFFFF, rsp_r = 5, rsp_dbz = 1. Latency is 37 without DIV_ZERO_BYPASS_EN and 2 with it.
- flush asserted at cycle 10 of a DIVU 1000/3 -> div_ena low for one cycle; no rsp_valid. A new DIVU 9/2 issued next gives rsp_q = 4, rsp_r = 1.
- reset_n pulsed low mid-WAIT -> all outputs at reset values immediately; req_ready = 1 after release.
